// File: rtl/mem_bus_arbiter.sv
// Shares the 8-bit memory bus between instruction fetch and the data port. Each
// access is split into byte cycles, and read bytes are reassembled little-endian.
module mem_bus_arbiter #(
    parameter int         AW     = 32,
    parameter logic [1:0] IO_SEL = 2'b11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_data,
    output logic          if_done,
    input  logic          flush,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_done,
    input  logic [7:0]    mem_din,
    output logic [7:0]    mem_dout,
    output logic [AW-1:0] mem_a,
    output logic          mem_wr,
    input  logic          io_buffer_full,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            own_data_q, own_data_d;
    logic [AW-1:0]   base_q, base_d;
    logic [2:0]      len_q, len_d;
    logic [3:0][7:0] wdata_q, wdata_d;
    logic [3:0][7:0] rbuf_q, rbuf_d;
    logic            hold_q, hold_d;
    logic [31:0]     if_data_q, if_data_d;
    logic [31:0]     d_rdata_q, d_rdata_d;

    logic            io_stall_s;
    logic            rd_last_s;
    logic            wr_last_s;
    logic            fetch_flush_s;
    logic [1:0]      cap_idx_s;
    logic [AW-1:0]   cur_addr_s;
    logic [3:0][7:0] rd_bytes_s;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            2'd0:    len = 3'd1;
            2'd1:    len = 3'd2;
            default: len = 3'd4;
        endcase
        return len;
    endfunction

    function automatic logic [31:0] zero_extend(input logic [31:0] bytes, input logic [2:0] len);
        logic [31:0] value;
        case (len)
            3'd1:    value = {24'd0, bytes[7:0]};
            3'd2:    value = {16'd0, bytes[15:0]};
            default: value = bytes;
        endcase
        return value;
    endfunction

    assign cur_addr_s    = base_q + {{(AW-3){1'b0}}, cnt_q};
    assign io_stall_s    = (base_q[17:16] == IO_SEL) && io_buffer_full;
    assign rd_last_s     = (cnt_q == len_q);
    assign wr_last_s     = (cnt_q == (len_q - 3'd1));
    assign fetch_flush_s = flush && !own_data_q;
    assign cap_idx_s     = cnt_q[1:0] - 2'd1;

    assign if_data = if_data_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != S_IDLE);

    // Merge the byte arriving on mem_din into the read buffer. A free-running RAM
    // re-reads mem_a while rdy is low, so the pending byte is taken only on the
    // first edge of a cycle and ignored on later frozen edges and the resume edge.
    always_comb begin
        rd_bytes_s = rbuf_q;
        if ((cnt_q != 3'd0) && !hold_q) begin
            rd_bytes_s[cap_idx_s] = mem_din;
        end else begin
            rd_bytes_s = rbuf_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: data requests win arbitration; a flush only aborts fetch reads.
    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    if (d_req) begin
                        state_d = d_we ? S_WR : S_RD;
                    end else if (if_req && !flush) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_RD: begin
                    if (fetch_flush_s) begin
                        state_d = S_IDLE;
                    end else if (rd_last_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
                S_WR: begin
                    if (!io_stall_s && wr_last_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WR;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Datapath registers: transfer context, byte counter, read buffer, result words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 3'd0;
            own_data_q <= 1'b0;
            base_q     <= '0;
            len_q      <= 3'd0;
            wdata_q    <= 32'd0;
            rbuf_q     <= 32'd0;
            hold_q     <= 1'b0;
            if_data_q  <= 32'd0;
            d_rdata_q  <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            own_data_q <= own_data_d;
            base_q     <= base_d;
            len_q      <= len_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            hold_q     <= hold_d;
            if_data_q  <= if_data_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Datapath next-state: latch the winning request, step the byte counter, and
    // publish the reassembled word on the edge that enters DONE.
    always_comb begin
        cnt_d      = cnt_q;
        own_data_d = own_data_q;
        base_d     = base_q;
        len_d      = len_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        hold_d     = 1'b0;
        if_data_d  = if_data_q;
        d_rdata_d  = d_rdata_q;
        if (state_q == S_RD) begin
            rbuf_d = rd_bytes_s;
            hold_d = !rdy;
        end else begin
            rbuf_d = rbuf_q;
            hold_d = 1'b0;
        end
        if (rdy) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = 3'd0;
                    if (d_req) begin
                        own_data_d = 1'b1;
                        base_d     = d_addr;
                        len_d      = size_to_len(d_size);
                        wdata_d    = d_wdata;
                    end else if (if_req && !flush) begin
                        own_data_d = 1'b0;
                        base_d     = if_addr;
                        len_d      = 3'd4;
                    end else begin
                        own_data_d = own_data_q;
                    end
                end
                S_RD: begin
                    if (rd_last_s && !fetch_flush_s) begin
                        if (own_data_q) begin
                            d_rdata_d = zero_extend(rd_bytes_s, len_q);
                        end else begin
                            if_data_d = zero_extend(rd_bytes_s, len_q);
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_WR: begin
                    if (!io_stall_s) begin
                        cnt_d = cnt_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_DONE:  cnt_d = cnt_q;
                default: cnt_d = cnt_q;
            endcase
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Bus and completion outputs. mem_wr is gated by rdy so a paused cycle never repeats a write.
    always_comb begin
        mem_a    = '0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        if_done  = 1'b0;
        d_done   = 1'b0;
        case (state_q)
            S_RD: begin
                if (cnt_q < len_q) begin
                    mem_a = cur_addr_s;
                end else begin
                    mem_a = '0;
                end
            end
            S_WR: begin
                if (!io_stall_s) begin
                    mem_a    = cur_addr_s;
                    mem_dout = wdata_q[cnt_q[1:0]];
                    mem_wr   = rdy;
                end else begin
                    mem_a  = '0;
                    mem_wr = 1'b0;
                end
            end
            S_DONE: begin
                if (own_data_q) begin
                    d_done = rdy;
                end else begin
                    if_done = rdy && !flush;
                end
            end
            default: begin
                mem_a  = '0;
                mem_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: byte RAM on the bus pins, a transaction-level
// reference memory, and one task per scenario with inline checks.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, if_req, flush, d_req, d_we, io_buffer_full;
    logic [1:0]  d_size;
    logic [31:0] if_addr, d_addr, d_wdata, if_data, d_rdata, mem_a;
    logic        if_done, d_done, mem_wr, busy;
    logic [7:0]  mem_din, mem_dout;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  ram     [0:65535];
    logic [7:0]  ref_ram [0:65535];
    bit          seeded;
    logic [31:0] wl_addr [0:1023];
    logic [7:0]  wl_data [0:1023];
    int          wcnt;
    logic [31:0] a_seen  [0:3];

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .IO_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .busy(busy)
    );

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 7 + (i >> 8) * 13 + 41);
    endfunction

    // Free-running synchronous RAM: read data appears the cycle after its address.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
            seeded <= 1'b1;
        end else begin
            mem_din <= ram[mem_a[15:0]];
            if (mem_wr) begin
                ram[mem_a[15:0]]   <= mem_dout;
                wl_addr[wcnt[9:0]] <= mem_a;
                wl_data[wcnt[9:0]] <= mem_dout;
                wcnt               <= wcnt + 1;
            end
        end
    end

    function automatic int len_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_ram[16'(a + 32'(i))];
        return v;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input int n);
        for (int i = 0; i < n; i++) ref_ram[16'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    // Check that the bus writes since log0 are exactly bytes 0..n-1 of wd at a, a+1, ...
    task automatic check_writes(input int log0, input logic [31:0] a, input logic [31:0] wd,
                                input int n, input string tag);
        bit bad;
        bad = 1'b0;
        tests_run++;
        if (wcnt - log0 != n) begin
            tests_failed++;
            $display("FAIL %s write_count got %0d want %0d", tag, wcnt - log0, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (wl_addr[(log0 + i) % 1024] !== a + 32'(i) ||
                    wl_data[(log0 + i) % 1024] !== wd[8*i +: 8]) bad = 1'b1;
            end
            if (bad) begin
                tests_failed++;
                $display("FAIL %s write_bytes first got %h:%h want %h:%h", tag,
                         wl_addr[log0 % 1024], wl_data[log0 % 1024], a, wd[7:0]);
            end
        end
    endtask

    // One complete transfer from IDLE; optional random rdy stalls lengthen it cycle for cycle.
    task automatic xfer(input bit is_fetch, input bit we, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit rnd_rdy, input string tag);
        int n, k, low, log0, exp_lat;
        bit got, spur, store;
        logic [31:0] exp_v, got_v;
        store = we && !is_fetch;
        n     = is_fetch ? 4 : len_of(size);
        exp_v = ref_read(addr, n);
        log0  = wcnt;
        @(posedge clk); #1;
        rdy = 1'b1;
        if (is_fetch) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wd;
        end
        k = 0; low = 0; got = 1'b0; spur = 1'b0;
        while (!got && k < 80) begin
            @(posedge clk); #1;
            k++;
            rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!rdy) low++;
            #1;
            if (k <= 4) a_seen[k-1] = mem_a;
            if ((is_fetch ? d_done : if_done) === 1'b1) spur = 1'b1;
            got = ((is_fetch ? if_done : d_done) === 1'b1);
        end
        if_req = 1'b0; d_req = 1'b0; rdy = 1'b1;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL %s done_timeout got none within %0d cycles", tag, k);
        end else begin
            exp_lat = n + (store ? 1 : 2) + low;
            tests_run++;
            if (k != exp_lat) begin
                tests_failed++;
                $display("FAIL %s latency got %0d want %0d", tag, k, exp_lat);
            end
            if (!store) begin
                got_v = is_fetch ? if_data : d_rdata;
                tests_run++;
                if (got_v !== exp_v) begin
                    tests_failed++;
                    $display("FAIL %s read_data got %h want %h", tag, got_v, exp_v);
                end
            end
        end
        tests_run++;
        if (spur) begin
            tests_failed++;
            $display("FAIL %s other_done got 1 want 0", tag);
        end
        @(posedge clk); #2;
        check_writes(log0, addr, wd, store ? n : 0, tag);
        if (store) ref_write(addr, wd, n);
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; if_req = 1'b0; flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
        d_size = 2'd0; if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if ({mem_a, mem_dout, mem_wr} !== 41'd0) begin
            tests_failed++;
            $display("FAIL reset_bus got a=%h d=%h wr=%b want 0", mem_a, mem_dout, mem_wr);
        end
        tests_run++;
        if ({if_done, d_done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_done got %b%b want 00", if_done, d_done);
        end
        tests_run++;
        if ({if_data, d_rdata} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_data got %h %h want 0", if_data, d_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #2;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
    endtask

    task automatic test_store_readback();
        xfer(1'b0, 1'b1, 2'd1, 32'h0000_03FF, 32'h0000_1234, 1'b0, "store_half");
        xfer(1'b0, 1'b0, 2'd2, 32'h0000_03FF, 32'd0, 1'b0, "readback_word");
        tests_run++;
        if (d_rdata[15:0] !== 16'h1234) begin
            tests_failed++;
            $display("FAIL readback_low got %h want 1234", d_rdata[15:0]);
        end
    endtask

    task automatic test_fetch();
        bit bad;
        xfer(1'b0, 1'b1, 2'd2, 32'h0000_0100, 32'h9300_0013, 1'b0, "preload_word");
        xfer(1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'd0, 1'b0, "fetch");
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (a_seen[i] !== 32'h100 + 32'(i)) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL fetch_addr_steps got %h %h %h %h want 100..103",
                     a_seen[0], a_seen[1], a_seen[2], a_seen[3]);
        end
        tests_run++;
        if (if_data !== 32'h9300_0013 || if_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_word_pulse got %h done=%b want 93000013 done=0", if_data, if_done);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        bit got, spur;
        xfer(1'b0, 1'b1, 2'd0, 32'h0000_2000, 32'h0000_00FF, 1'b0, "preload_byte");
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h2000;
        k = 0; got = 1'b0; spur = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk); #2;
            k++;
            if (if_done === 1'b1) spur = 1'b1;
            got = (d_done === 1'b1);
        end
        d_req = 1'b0;
        tests_run++;
        if (!got || k != 3 || spur) begin
            tests_failed++;
            $display("FAIL simul_data_first got k=%0d spur=%b want k=3 spur=0", k, spur);
        end
        tests_run++;
        if (d_rdata !== 32'h0000_00FF) begin
            tests_failed++;
            $display("FAIL simul_rdata got %h want 000000ff", d_rdata);
        end
        k = 0; got = 1'b0;
        while (!got && k < 20) begin
            @(posedge clk); #2;
            k++;
            got = (if_done === 1'b1);
        end
        if_req = 1'b0;
        tests_run++;
        if (!got || k != 7 || if_data !== 32'h9300_0013) begin
            tests_failed++;
            $display("FAIL simul_fetch_after got k=%0d data=%h want k=7 data=93000013", k, if_data);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_io_store();
        int log0;
        bit bad;
        log0 = wcnt;
        bad  = 1'b0;
        @(posedge clk); #1;
        io_buffer_full = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h0003_0000; d_wdata = 32'h0000_0041;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (mem_wr !== 1'b0 || mem_a !== 32'd0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL io_stall got a write or nonzero mem_a want none");
        end
        @(posedge clk); #1;
        io_buffer_full = 1'b0;
        #1;
        tests_run++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h0003_0000 || mem_dout !== 8'h41) begin
            tests_failed++;
            $display("FAIL io_write got wr=%b a=%h d=%h want 1 30000 41", mem_wr, mem_a, mem_dout);
        end
        @(posedge clk); #2;
        tests_run++;
        if (d_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL io_done got %b want 1", d_done);
        end
        d_req = 1'b0;
        @(posedge clk); #2;
        check_writes(log0, 32'h0003_0000, 32'h41, 1, "io_single_write");
        ref_write(32'h0003_0000, 32'h41, 1);
    endtask

    task automatic test_flush();
        bit spur;
        spur = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h200;
        repeat (3) begin
            @(posedge clk); #2;
            if (if_done === 1'b1) spur = 1'b1;
        end
        tests_run++;
        if (mem_a !== 32'h202) begin
            tests_failed++;
            $display("FAIL flush_cnt2_addr got %h want 202", mem_a);
        end
        flush = 1'b1; if_addr = 32'h104;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        tests_run++;
        if (mem_a !== 32'd0 || busy !== 1'b0 || if_done !== 1'b0 || spur) begin
            tests_failed++;
            $display("FAIL flush_abort got a=%h busy=%b done=%b spur=%b want 0 0 0 0",
                     mem_a, busy, if_done, spur);
        end
        if_req = 1'b0;
        xfer(1'b1, 1'b0, 2'd0, 32'h104, 32'd0, 1'b0, "fetch_after_flush");
    endtask

    task automatic test_rdy_pause();
        int k, log0;
        bit got, bad, spur;
        logic [31:0] exp_v;
        exp_v = ref_read(32'h100, 4);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h100; rdy = 1'b1;
        k = 0; got = 1'b0; bad = 1'b0;
        while (!got && k < 40) begin
            @(posedge clk); #1;
            k++;
            rdy = !(k >= 2 && k <= 5);
            #1;
            if (k >= 2 && k <= 5 && mem_a !== 32'h101) bad = 1'b1;
            got = (d_done === 1'b1);
        end
        d_req = 1'b0; rdy = 1'b1;
        tests_run++;
        if (!got || k != 10 || bad) begin
            tests_failed++;
            $display("FAIL pause_timing got k=%0d hold_bad=%b want k=10 hold_bad=0", k, bad);
        end
        tests_run++;
        if (d_rdata !== exp_v) begin
            tests_failed++;
            $display("FAIL pause_data got %h want %h", d_rdata, exp_v);
        end
        @(posedge clk); #2;
        log0 = wcnt; bad = 1'b0; spur = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 32'h500; d_wdata = 32'hA1B2_C3D4;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            rdy = !(c == 2 || c == 3);
            if (c == 5) rst = 1'b0;
            #1;
            if ((c == 2 || c == 3) && mem_wr !== 1'b0) bad = 1'b1;
            if (d_done === 1'b1) spur = 1'b1;
        end
        d_req = 1'b0; rdy = 1'b1;
        tests_run++;
        if (bad || spur) begin
            tests_failed++;
            $display("FAIL pause_store got wr_in_pause=%b done=%b want 0 0", bad, spur);
        end
        tests_run++;
        if ({mem_a, mem_dout, mem_wr, if_done, d_done, if_data, d_rdata, busy} !== 108'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs got a=%h wr=%b busy=%b rd=%h want all 0",
                     mem_a, mem_wr, busy, d_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #2;
        check_writes(log0, 32'h500, 32'hA1B2_C3D4, 2, "midreset_writes");
        ref_write(32'h500, 32'hA1B2_C3D4, 2);
        xfer(1'b0, 1'b0, 2'd2, 32'h500, 32'd0, 1'b0, "midreset_readback");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0:       a = 32'h0000_1000 + 32'($urandom_range(0, 63));
                1:       a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                default: a = 32'h0003_0010 + 32'($urandom_range(0, 15));
            endcase
            xfer($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), a, $urandom, 1'b1, "random");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ref_ram[i] = init_byte(i);
        test_reset();
        test_store_readback();
        test_fetch();
        test_simultaneous();
        test_io_store();
        test_flush();
        test_rdy_pause();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
